// File: rtl/mfcc_dct_pkg.sv
// Shared constants, FSM encoding and the DCT-II weight generator for the MFCC cepstrum stage.
package mfcc_pkg;
  localparam int  NUM_FILTERS_DEF = 40;
  localparam int  NUM_CEPS_DEF    = 12;
  localparam int  Q_FRAC          = 15;
  localparam real PI              = 3.14159265358979323846;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  // Orthonormal DCT-II weight in Q1.15, rounded half away from zero; evaluated at elaboration only.
  function automatic int dct_weight(input int k, input int n, input int nf);
    real s;
    real v;
    s = (k == 0) ? $sqrt(1.0 / nf) : $sqrt(2.0 / nf);
    v = real'(1 << Q_FRAC) * s * $cos(PI * k * (2 * n + 1) / (2.0 * nf));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction
endpackage

// File: rtl/mfcc_dct_if.sv
// Frame-load / coefficient-stream bundle of the DCT stage; slave is the DCT, master the driver.
interface mfcc_dct_if import mfcc_pkg::*; #(
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int NUM_CEPS    = NUM_CEPS_DEF,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 32
);
  logic                                in_valid_i;
  logic [$clog2(NUM_FILTERS)-1:0]      in_ptr_i;
  logic signed [IN_WIDTH-1:0]          in_data_i;
  logic                                start_i;
  logic                                busy_o;
  logic                                ceps_valid_o;
  logic [$clog2(NUM_CEPS)-1:0]         ceps_ptr_o;
  logic signed [OUT_WIDTH-1:0]         ceps_o;
  logic                                done_o;

  modport master (
    output in_valid_i, in_ptr_i, in_data_i, start_i,
    input  busy_o, ceps_valid_o, ceps_ptr_o, ceps_o, done_o
  );
  modport slave (
    input  in_valid_i, in_ptr_i, in_data_i, start_i,
    output busy_o, ceps_valid_o, ceps_ptr_o, ceps_o, done_o
  );
endinterface

// File: rtl/mfcc_dct_coef_rom.sv
// Combinational w[k][n] lookup; the table is filled at elaboration from the package generator.
module dct_coef_rom import mfcc_pkg::*; #(
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int NUM_CEPS    = NUM_CEPS_DEF,
  parameter int COEF_WIDTH  = 16
) (
  input  logic [$clog2(NUM_CEPS)-1:0]    i_k,
  input  logic [$clog2(NUM_FILTERS)-1:0] i_n,
  output logic signed [COEF_WIDTH-1:0]   o_w
);
  logic signed [COEF_WIDTH-1:0] w_tbl [NUM_CEPS][NUM_FILTERS];

  for (genvar gk = 0; gk < NUM_CEPS; gk++) begin : g_k
    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_n
      localparam int W = dct_weight(gk, gn, NUM_FILTERS);
      assign w_tbl[gk][gn] = COEF_WIDTH'(W);
    end
  end

  assign o_w = w_tbl[i_k][i_n];
endmodule

// File: rtl/mfcc_dct.sv
// DCT-II cepstrum stage: buffers one log-mel frame, then one MAC per cycle per coefficient.
// state  | meaning
// IDLE   | buffer writable, waiting for start
// MAC    | accumulate x[n]*w[k][n], n = 0..N-1
// OUT    | publish rounded/saturated c[k], clear accumulator
// DONE   | frame finished, done pulse follows
module mfcc_dct import mfcc_pkg::*; #(
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int NUM_CEPS    = NUM_CEPS_DEF,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int COEF_WIDTH  = 16
) (
  input logic        clk,
  input logic        rst_n,
  mfcc_dct_if.slave  bus
);
  localparam int PW = $clog2(NUM_FILTERS);
  localparam int KW = $clog2(NUM_CEPS);
  localparam int AW = IN_WIDTH + COEF_WIDTH + PW;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                       r_state, w_state_nxt;
  logic [PW-1:0]                r_n;
  logic [KW-1:0]                r_k;
  logic signed [IN_WIDTH-1:0]   r_buf [NUM_FILTERS];
  logic signed [AW-1:0]         r_acc;
  logic                         r_busy, r_valid, r_done;
  logic [KW-1:0]                r_ptr;
  logic signed [OUT_WIDTH-1:0]  r_ceps;
  logic signed [COEF_WIDTH-1:0] w_coef;
  logic signed [AW-1:0]         w_prod, w_sum, w_shift;
  logic signed [OUT_WIDTH-1:0]  w_ceps;

  dct_coef_rom #(.NUM_FILTERS(NUM_FILTERS), .NUM_CEPS(NUM_CEPS), .COEF_WIDTH(COEF_WIDTH)) u_rom (
    .i_k (r_k),
    .i_n (r_n),
    .o_w (w_coef)
  );

  assign w_prod  = AW'(r_buf[r_n]) * AW'(w_coef);
  assign w_sum   = r_acc + AW'(1 << (Q_FRAC - 1));
  assign w_shift = w_sum >>> Q_FRAC;

  always_comb begin
    w_ceps = w_shift[OUT_WIDTH-1:0];
    if (w_shift > SAT_MAX)      w_ceps = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_shift < SAT_MIN) w_ceps = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_nxt = S_MAC;
      S_MAC:   if (r_n == PW'(NUM_FILTERS - 1)) w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = (r_k == KW'(NUM_CEPS - 1)) ? S_DONE : S_MAC;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame slots are only writable between frames and keep their value across frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) r_buf[i] <= '0;
    end else if (r_state == S_IDLE && bus.in_valid_i &&
                 {1'b0, bus.in_ptr_i} < (PW+1)'(NUM_FILTERS)) begin
      r_buf[bus.in_ptr_i] <= bus.in_data_i;
    end
  end

  // Outputs are registered, so each strobe trails its state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ptr   <= '0;
      r_ceps  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_acc <= '0;
          r_k   <= '0;
          r_n   <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          r_n   <= (r_n == PW'(NUM_FILTERS - 1)) ? '0 : r_n + 1'b1;
        end
        S_OUT: begin
          r_valid <= 1'b1;
          r_ptr   <= r_k;
          r_ceps  <= w_ceps;
          r_acc   <= '0;
          if (r_k != KW'(NUM_CEPS - 1)) r_k <= r_k + 1'b1;
        end
        S_DONE:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.ceps_valid_o = r_valid;
  assign bus.ceps_ptr_o   = r_ptr;
  assign bus.ceps_o       = r_ceps;
  assign bus.done_o       = r_done;
endmodule

// File: tb/tb_mfcc_dct.sv
// Directed + randomized bench for mfcc_dct against a floating-point-derived DCT-II reference.
module tb_mfcc_dct;
  localparam int  NF = 40;
  localparam int  NC = 12;
  localparam int  IW = 32;
  localparam int  OW = 32;
  localparam int  CW = 16;
  localparam int  PERIOD = NF + 1;
  localparam real PI_TB = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mfcc_dct_if #(.NUM_FILTERS(NF), .NUM_CEPS(NC), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  mfcc_dct #(.NUM_FILTERS(NF), .NUM_CEPS(NC), .IN_WIDTH(IW), .OUT_WIDTH(OW), .COEF_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_chk = 0;
  int     n_pass = 0;
  longint wt [NC][NF];
  longint xm [NF];
  longint exp_c [NC];
  longint got_c [NC];

  task automatic check(input string tag, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic check_tol(input string tag, input longint obs, input longint expv, input longint tol);
    n_chk++;
    assert (obs >= expv - tol && obs <= expv + tol) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
  endtask

  function automatic longint ideal_weight(input int k, input int n);
    real s, v;
    s = (k == 0) ? $sqrt(1.0 / NF) : $sqrt(2.0 / NF);
    v = 32768.0 * s * $cos(PI_TB * k * (2 * n + 1) / (2.0 * NF));
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  // Reference: plain dot product, round-to-nearest by +2^14 then arithmetic shift, then clip.
  function automatic void model();
    longint s;
    for (int k = 0; k < NC; k++) begin
      s = 0;
      for (int n = 0; n < NF; n++) s += xm[n] * wt[k][n];
      s = (s + 64'sd16384) >>> 15;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      exp_c[k] = s;
    end
  endfunction

  task automatic write_slot(input int ptr, input int data);
    bus.in_valid_i = 1'b1;
    bus.in_ptr_i   = 6'(ptr);
    bus.in_data_i  = data;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    if (ptr < NF) xm[ptr] = longint'(data);
  endtask

  task automatic fill(input int data);
    for (int n = 0; n < NF; n++) write_slot(n, data);
  endtask

  task automatic run_frame(input string tag, input bit disturb, input bit wr_now,
                           input int wr_ptr, input int wr_data);
    int c;
    int k_seen;
    bit done_seen;
    bus.start_i = 1'b1;
    if (wr_now) begin
      bus.in_valid_i = 1'b1;
      bus.in_ptr_i   = 6'(wr_ptr);
      bus.in_data_i  = wr_data;
      xm[wr_ptr]     = longint'(wr_data);
    end
    model();
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    c = 0;
    k_seen = 0;
    done_seen = 1'b0;
    while (!done_seen && c < 600) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) check({tag, "_busy_rise"}, bus.busy_o, 1);
      if (bus.ceps_valid_o) begin
        if (k_seen < NC) begin
          check({tag, "_ptr"}, bus.ceps_ptr_o, k_seen);
          check({tag, "_valid_cycle"}, c, (k_seen + 1) * PERIOD);
          check({tag, "_ceps"}, longint'(bus.ceps_o), exp_c[k_seen]);
          got_c[k_seen] = longint'(bus.ceps_o);
        end else begin
          check({tag, "_extra_valid"}, k_seen, NC - 1);
        end
        k_seen++;
      end
      if (bus.done_o) begin
        done_seen = 1'b1;
        check({tag, "_done_cycle"}, c, NC * PERIOD + 1);
        check({tag, "_ceps_count"}, k_seen, NC);
        check({tag, "_busy_at_done"}, bus.busy_o, 1);
      end
      if (disturb) begin
        if (c == 5 || c == 41 || c == 200 || c == 492) begin
          bus.start_i    = 1'b1;
          bus.in_valid_i = 1'b1;
          bus.in_ptr_i   = 6'($urandom_range(0, NF - 1));
          bus.in_data_i  = int'($urandom());
        end else begin
          bus.start_i    = 1'b0;
          bus.in_valid_i = 1'b0;
        end
      end
    end
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    if (!done_seen) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic random_subset(input int count);
    for (int i = 0; i < count; i++)
      write_slot($urandom_range(0, NF - 1), int'($urandom()) >>> $urandom_range(0, 14));
  endtask

  initial begin
    int dones;
    bus.in_valid_i = 1'b0;
    bus.in_ptr_i   = '0;
    bus.in_data_i  = '0;
    bus.start_i    = 1'b0;
    for (int k = 0; k < NC; k++)
      for (int n = 0; n < NF; n++) wt[k][n] = ideal_weight(k, n);
    for (int n = 0; n < NF; n++) xm[n] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.ceps_valid_o, 0);
    check("rst_ptr", bus.ceps_ptr_o, 0);
    check("rst_ceps", longint'(bus.ceps_o), 0);
    check("rst_done", bus.done_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("zero", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < NC; k++) check("zero_val", got_c[k], 0);

    fill(1000);
    run_frame("const", 1'b0, 1'b0, 0, 0);
    check_tol("const_c0", got_c[0], 6325, 1);
    for (int k = 1; k < NC; k++) check_tol("const_ck", got_c[k], 0, 2);

    fill(0);
    write_slot(0, 32767);
    run_frame("impulse", 1'b0, 1'b0, 0, 0);
    check_tol("impulse_c0", got_c[0], 5181, 1);
    check_tol("impulse_c1", got_c[1], 7321, 1);

    fill(32'sh7fffffff);
    run_frame("sat_max", 1'b0, 1'b0, 0, 0);
    check("sat_max_c0", got_c[0], 64'sd2147483647);
    fill(int'(32'h80000000));
    run_frame("sat_min", 1'b0, 1'b0, 0, 0);
    check("sat_min_c0", got_c[0], -64'sd2147483648);

    // Partial rewrites: untouched slots keep the saturating values from the previous frame.
    random_subset(25);
    run_frame("rand_a", 1'b0, 1'b0, 0, 0);
    fill(0);
    random_subset(30);
    run_frame("rand_b", 1'b0, 1'b0, 0, 0);
    run_frame("back2back", 1'b0, 1'b0, 0, 0);

    random_subset(10);
    run_frame("wr_start", 1'b0, 1'b1, 7, -123456789);

    random_subset(10);
    write_slot(45, int'($urandom()));
    run_frame("disturbed", 1'b1, 1'b0, 0, 0);

    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_valid", bus.ceps_valid_o, 0);
    check("midrst_ceps", longint'(bus.ceps_o), 0);
    check("midrst_done", bus.done_o, 0);
    for (int n = 0; n < NF; n++) xm[n] = 0;
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (bus.done_o) dones++;
    end
    check("midrst_no_done", dones, 0);

    random_subset(12);
    run_frame("post_rst", 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("final_busy_low", bus.busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
